// File: rtl/channel_pkg.sv
// Shared channel types and default widths for the channel collector slice.
package channel_pkg;
    localparam int unsigned CH_DATA_W = 8;
    localparam int unsigned CH_NUM    = 4;

    typedef logic [CH_DATA_W-1:0]      ch_data_t;
    typedef logic [$clog2(CH_NUM)-1:0] ch_id_t;
endpackage

// File: rtl/channel_fifo.sv
// Per-channel synchronous FIFO; wrap-bit binary pointers, full/empty from pointer compare.
module channel_fifo
    import channel_pkg::*;
#(
    parameter int unsigned DATA_W = CH_DATA_W,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              full,
    output logic              empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]       wptr;
    logic [AW:0]       rptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              do_pop;
    logic              do_push;

    assign empty    = (wptr == rptr);
    assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop   = pop && !empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign do_push  = push && (!full || do_pop);
    assign data_out = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + (AW+1)'(1);
            if (do_pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= data_in;
    end
endmodule

// File: rtl/channel_rr_collector.sv
// Captures free-running channel beats into per-channel FIFOs and merges them
// round-robin into one registered valid/ready stream tagged with the channel id.
module channel_rr_collector
    import channel_pkg::*;
#(
    parameter int unsigned NUM_CH     = CH_NUM,
    parameter int unsigned DATA_W     = CH_DATA_W,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*DATA_W-1:0] ch_data_i,
    input  logic [NUM_CH-1:0]        ch_valid_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [DATA_W-1:0]        out_data_o,
    output logic [$clog2(NUM_CH)-1:0] out_ch_o,
    output logic [NUM_CH-1:0]        fifo_full_o,
    output logic [NUM_CH*CNT_W-1:0]  drop_cnt_o,
    input  logic                     clr_drop_i
);
    localparam int unsigned ID_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] pop;
    logic [DATA_W-1:0] fifo_dout [NUM_CH];
    logic [CNT_W-1:0]  drop_cnt  [NUM_CH];
    logic [ID_W-1:0]   last_grant;
    logic [ID_W-1:0]   grant_id;
    logic              grant_vld;
    logic              load_en;

    assign load_en     = !out_valid_o || out_ready_i;
    assign fifo_full_o = full;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign pop[k] = load_en && grant_vld && (grant_id == ID_W'(k));
        assign drop_cnt_o[k*CNT_W +: CNT_W] = drop_cnt[k];

        channel_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (FIFO_DEPTH)
        ) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .push     (ch_valid_i[k]),
            .pop      (pop[k]),
            .data_in  (ch_data_i[k*DATA_W +: DATA_W]),
            .data_out (fifo_dout[k]),
            .full     (full[k]),
            .empty    (empty[k])
        );

        // Saturating drop counter; clear wins over a same-cycle drop.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                drop_cnt[k] <= '0;
            end else if (clr_drop_i) begin
                drop_cnt[k] <= '0;
            end else if (ch_valid_i[k] && full[k] && !pop[k] && (drop_cnt[k] != '1)) begin
                drop_cnt[k] <= drop_cnt[k] + CNT_W'(1);
            end
        end
    end

    // First non-empty channel after last_grant, wrapping modulo NUM_CH.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        for (int i = 1; i <= int'(NUM_CH); i++) begin
            logic [ID_W-1:0] cand;
            cand = ID_W'((int'(last_grant) + i) % int'(NUM_CH));
            if (!grant_vld && !empty[cand]) begin
                grant_vld = 1'b1;
                grant_id  = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_ch_o    <= '0;
            last_grant  <= ID_W'(NUM_CH - 1);
        end else if (load_en) begin
            out_valid_o <= grant_vld;
            if (grant_vld) begin
                out_data_o <= fifo_dout[grant_id];
                out_ch_o   <= grant_id;
                last_grant <= grant_id;
            end
        end
    end
endmodule

// File: tb/tb_channel_rr_collector.sv
// Directed bench for channel_rr_collector: vector table plus multi-cycle sequences.
module tb_channel_rr_collector;
    logic        clk;
    logic        rst;
    logic [31:0] ch_data;
    logic [3:0]  ch_valid;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic [3:0]  fifo_full;
    logic [31:0] drop_cnt;
    logic        clr_drop;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0]  v;
        logic [31:0] d;
        logic        exp_v;
        logic [7:0]  exp_d;
        logic [1:0]  exp_ch;
    } vec_t;

    vec_t tbl [23];

    channel_rr_collector dut (
        .clk         (clk),
        .rst         (rst),
        .ch_data_i   (ch_data),
        .ch_valid_i  (ch_valid),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_ch_o    (out_ch),
        .fifo_full_o (fifo_full),
        .drop_cnt_o  (drop_cnt),
        .clr_drop_i  (clr_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; ch_data = '0; ch_valid = '0; out_ready = 1'b1; clr_drop = 1'b0;

        // Table: all-channel burst, single ch2 beat, then ch0/ch3 fairness and drain.
        tbl[0]  = '{4'b1111, 32'h13121110, 1'b0, 8'h00, 2'd0};
        tbl[1]  = '{4'b0000, 32'h0,        1'b1, 8'h10, 2'd0};
        tbl[2]  = '{4'b0000, 32'h0,        1'b1, 8'h11, 2'd1};
        tbl[3]  = '{4'b0000, 32'h0,        1'b1, 8'h12, 2'd2};
        tbl[4]  = '{4'b0000, 32'h0,        1'b1, 8'h13, 2'd3};
        tbl[5]  = '{4'b0000, 32'h0,        1'b0, 8'h13, 2'd3};
        tbl[6]  = '{4'b0100, 32'h005A0000, 1'b0, 8'h13, 2'd3};
        tbl[7]  = '{4'b0000, 32'h0,        1'b1, 8'h5A, 2'd2};
        tbl[8]  = '{4'b0000, 32'h0,        1'b0, 8'h5A, 2'd2};
        tbl[9]  = '{4'b1001, 32'hD30000A0, 1'b0, 8'h5A, 2'd2};
        tbl[10] = '{4'b1001, 32'hD30000A0, 1'b1, 8'hD3, 2'd3};
        tbl[11] = '{4'b1001, 32'hD30000A0, 1'b1, 8'hA0, 2'd0};
        tbl[12] = '{4'b1001, 32'hD30000A0, 1'b1, 8'hD3, 2'd3};
        tbl[13] = '{4'b1001, 32'hD30000A0, 1'b1, 8'hA0, 2'd0};
        tbl[14] = '{4'b1001, 32'hD30000A0, 1'b1, 8'hD3, 2'd3};
        tbl[15] = '{4'b0000, 32'h0,        1'b1, 8'hA0, 2'd0};
        tbl[16] = '{4'b0000, 32'h0,        1'b1, 8'hD3, 2'd3};
        tbl[17] = '{4'b0000, 32'h0,        1'b1, 8'hA0, 2'd0};
        tbl[18] = '{4'b0000, 32'h0,        1'b1, 8'hD3, 2'd3};
        tbl[19] = '{4'b0000, 32'h0,        1'b1, 8'hA0, 2'd0};
        tbl[20] = '{4'b0000, 32'h0,        1'b1, 8'hD3, 2'd3};
        tbl[21] = '{4'b0000, 32'h0,        1'b1, 8'hA0, 2'd0};
        tbl[22] = '{4'b0000, 32'h0,        1'b0, 8'hA0, 2'd0};

        #12;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data",  32'(out_data),  32'd0);
        chk("rst_ch",    32'(out_ch),    32'd0);
        chk("rst_full",  32'(fifo_full), 32'd0);
        chk("rst_drop",  drop_cnt,       32'd0);
        rst = 1'b0;

        for (int i = 0; i < 23; i++) begin
            ch_valid = tbl[i].v;
            ch_data  = tbl[i].d;
            step();
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(tbl[i].exp_v));
            chk($sformatf("vec%0d_data", i),  32'(out_data),  32'(tbl[i].exp_d));
            chk($sformatf("vec%0d_ch", i),    32'(out_ch),    32'(tbl[i].exp_ch));
        end
        chk("vec_drops", drop_cnt, 32'd0);

        // Backpressure and overflow on ch0.
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ch_valid = 4'b0001;
            ch_data  = 32'(i);
            step();
            chk($sformatf("bp%0d_valid", i), 32'(out_valid), (i == 0) ? 32'd0 : 32'd1);
            if (i > 0) chk($sformatf("bp%0d_data", i), 32'(out_data), 32'h00);
            if (i >= 4) chk($sformatf("bp%0d_full", i), 32'(fifo_full[0]), 32'd1);
        end
        chk("bp_drop0", 32'(drop_cnt[7:0]), 32'd1);
        ch_valid  = '0;
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk($sformatf("drain%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("drain%0d_data", i),  32'(out_data),  32'(i));
            if (i == 1) chk("drain_full_clr", 32'(fifo_full[0]), 32'd0);
        end
        step();
        chk("drain_end_valid", 32'(out_valid), 32'd0);

        // Saturation and clear on ch1.
        out_ready = 1'b0;
        ch_valid  = 4'b0010;
        ch_data   = 32'h00004100;
        for (int i = 0; i < 259; i++) step();
        chk("sat_pre", 32'(drop_cnt[15:8]), 32'd254);
        for (int i = 0; i < 46; i++) step();
        chk("sat_hold",  32'(drop_cnt[15:8]), 32'd255);
        chk("sat_full1", 32'(fifo_full[1]),   32'd1);
        chk("sat_drop0", 32'(drop_cnt[7:0]),  32'd1);
        clr_drop = 1'b1;
        step();
        clr_drop = 1'b0;
        chk("clr_drop1", 32'(drop_cnt[15:8]), 32'd0);
        chk("clr_drop0", 32'(drop_cnt[7:0]),  32'd0);
        step();
        chk("post_clr_drop1", 32'(drop_cnt[15:8]), 32'd1);
        out_ready = 1'b1;
        step();
        chk("full_pop_drop1", 32'(drop_cnt[15:8]), 32'd1);
        chk("full_pop_full1", 32'(fifo_full[1]),   32'd1);
        chk("full_pop_valid", 32'(out_valid),      32'd1);
        out_ready = 1'b0;
        ch_valid  = '0;

        // Asynchronous reset between edges.
        step();
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_full",  32'(fifo_full), 32'd0);
        chk("arst_drop",  drop_cnt,       32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        step();
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        ch_valid = 4'b0011;
        ch_data  = 32'h00006261;
        step();
        ch_valid = '0;
        chk("rr0_valid", 32'(out_valid), 32'd0);
        step();
        chk("rr1_valid", 32'(out_valid), 32'd1);
        chk("rr1_ch",    32'(out_ch),    32'd0);
        chk("rr1_data",  32'(out_data),  32'h61);
        step();
        chk("rr2_ch",    32'(out_ch),    32'd1);
        chk("rr2_data",  32'(out_data),  32'h62);
        step();
        chk("rr3_valid", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
